// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_IMUL = 2'b01,
        OP_DIV  = 2'b10,
        OP_IDIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_ITER = 2'b10,
        S_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiplies,
// restoring shift-subtract for divides. The quotient bit is returned separately.
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_top;
    logic [WIDTH:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Top WIDTH+1 bits of the accumulator after a one-bit left shift.
        sub_top  = acc[2*WIDTH-1:WIDTH-1];
        sub_diff = sub_top - {1'b0, opnd};
        q_bit    = 1'b0;
        acc_next = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            q_bit    = ~sub_diff[WIDTH];
            acc_next = {(q_bit ? sub_diff[WIDTH-1:0] : sub_top[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/IMUL/DIV/IDIV unit with start/busy/done handshake, one bit per clock.
// Build option MULDIV_EARLY_EXIT_EN lets multiplies stop once the multiplier is exhausted.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             byteop,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             cf_of,
    output logic             div_exc,
    output logic [1:0]       dbg_state
);

    localparam int W = WIDTH;
    localparam int H = WIDTH / 2;
    localparam logic [W-1:0] QMAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] QMAX_B = {{(H+1){1'b0}}, {(H-1){1'b1}}};

    // Handshake: start is honoured only in S_IDLE; busy covers the edge after
    // start up to the completing edge, which raises done for exactly one cycle.
    state_t           state;
    op_t              op_q;
    logic             byte_q;
    logic [W-1:0]     a_hi_q, a_lo_q, b_q;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     opnd;
    logic [CNT_W-1:0] cnt;
    logic             res_neg, rem_neg, hi_ge;

    logic             is_div, is_sgn;
    logic [CNT_W-1:0] n_val;
    logic [W-1:0]     mx, my, mx_mag, my_mag, dvs, dvs_mag;
    logic [2*W-1:0]   dvd, dvd_mag;
    logic             mx_neg, my_neg, dvd_neg, dvs_neg, div_zero;
    logic [2*W-1:0]   init_acc;
    logic [W-1:0]     init_opnd;
    logic             prep_neg, prep_rem_neg, prep_hi_ge;

    logic [2*W-1:0]   step_acc_in, step_acc_out, acc_nx;
    logic [W-1:0]     step_opnd;
    logic             step_q;
    logic             mul_idle;

    logic [CNT_W-1:0] shamt;
    logic [2*W-1:0]   prod_mag, prod;
    logic [W-1:0]     q_mag, r_mag, q_val, r_val, q_lim;
    logic             div_ovf;
    logic [W-1:0]     fix_lo, fix_hi;
    logic             fix_cf;

    assign dbg_state = state;

    // Operand conditioning: sign extension, magnitudes and the initial accumulator.
    always_comb begin
        is_div = op_q[1];
        is_sgn = op_q[0];
        n_val  = byte_q ? CNT_W'(H) : CNT_W'(W);
        if (byte_q) begin
            mx  = {{H{is_sgn & a_lo_q[H-1]}}, a_lo_q[H-1:0]};
            my  = {{H{is_sgn & b_q[H-1]}}, b_q[H-1:0]};
            dvd = {{W{is_sgn & a_lo_q[W-1]}}, a_lo_q};
            dvs = {{H{is_sgn & b_q[H-1]}}, b_q[H-1:0]};
        end else begin
            mx  = a_lo_q;
            my  = b_q;
            dvd = {a_hi_q, a_lo_q};
            dvs = b_q;
        end
        mx_neg   = is_sgn & mx[W-1];
        my_neg   = is_sgn & my[W-1];
        dvd_neg  = is_sgn & dvd[2*W-1];
        dvs_neg  = is_sgn & dvs[W-1];
        mx_mag   = mx_neg ? -mx : mx;
        my_mag   = my_neg ? -my : my;
        dvd_mag  = dvd_neg ? -dvd : dvd;
        dvs_mag  = dvs_neg ? -dvs : dvs;
        div_zero = (dvs == '0);

        if (is_div) begin
            init_opnd = dvs_mag;
            // Byte dividend: high half in the remainder slot, low half queued to shift in.
            if (byte_q)
                init_acc = {{H{1'b0}}, dvd_mag[W-1:H], dvd_mag[H-1:0], {H{1'b0}}};
            else
                init_acc = dvd_mag;
            prep_neg = dvd_neg ^ dvs_neg;
        end else begin
            init_opnd = mx_mag;
            init_acc  = {{W{1'b0}}, my_mag};
            prep_neg  = mx_neg ^ my_neg;
        end
        prep_rem_neg = dvd_neg;
        // Restoring division is only exact when the high part is below the divisor.
        prep_hi_ge   = is_div && (init_acc[2*W-1:W] >= dvs_mag);
    end

    // The first iteration happens in S_PREP directly on the conditioned operands.
    always_comb begin
        step_acc_in = (state == S_PREP) ? init_acc : acc;
        step_opnd   = (state == S_PREP) ? init_opnd : opnd;
    end

    muldiv_step #(.WIDTH(W)) u_step (
        .acc      (step_acc_in),
        .opnd     (step_opnd),
        .is_div   (is_div),
        .acc_next (step_acc_out),
        .q_bit    (step_q)
    );

    assign acc_nx = step_acc_out | {{(2*W-1){1'b0}}, step_q};

`ifdef MULDIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] cnt_nx, k_nx;
    logic [W-1:0]     left_mask;
    always_comb begin
        cnt_nx    = (state == S_PREP) ? n_val - 1'b1 : cnt - 1'b1;
        k_nx      = n_val - cnt_nx;
        left_mask = {W{1'b1}} >> k_nx;
        mul_idle  = !op_q[1] && ((acc_nx[W-1:0] & left_mask) == '0);
    end
`else
    assign mul_idle = 1'b0;
`endif

    // Final alignment, sign correction, overflow check and result placement.
    always_comb begin
        shamt    = CNT_W'(W) - n_val + cnt;
        prod_mag = acc >> shamt;
        prod     = res_neg ? -prod_mag : prod_mag;
        q_mag    = acc[W-1:0];
        r_mag    = acc[2*W-1:W];
        q_val    = res_neg ? -q_mag : q_mag;
        r_val    = rem_neg ? -r_mag : r_mag;
        q_lim    = byte_q ? QMAX_B : QMAX_W;
        div_ovf  = hi_ge | (is_sgn & (q_mag > q_lim));
        fix_cf   = 1'b0;
        if (is_div) begin
            if (byte_q) begin
                fix_lo = {r_val[H-1:0], q_val[H-1:0]};
                fix_hi = '0;
            end else begin
                fix_lo = q_val;
                fix_hi = r_val;
            end
        end else if (byte_q) begin
            fix_lo = prod[W-1:0];
            fix_hi = '0;
            fix_cf = is_sgn ? (prod[W-1:H] != {H{prod[H-1]}}) : (prod[W-1:H] != '0);
        end else begin
            fix_lo = prod[W-1:0];
            fix_hi = prod[2*W-1:W];
            fix_cf = is_sgn ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= OP_MUL;
            byte_q  <= 1'b0;
            a_hi_q  <= '0;
            a_lo_q  <= '0;
            b_q     <= '0;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi_ge   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div_exc <= 1'b0;
            cf_of   <= 1'b0;
            res_lo  <= '0;
            res_hi  <= '0;
        end else begin
            done    <= 1'b0;
            div_exc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(op);
                        byte_q <= byteop;
                        a_hi_q <= a_hi;
                        a_lo_q <= a_lo;
                        b_q    <= b;
                        busy   <= 1'b1;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (is_div && div_zero) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        div_exc <= 1'b1;
                        cf_of   <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        acc     <= acc_nx;
                        opnd    <= init_opnd;
                        cnt     <= n_val - 1'b1;
                        res_neg <= prep_neg;
                        rem_neg <= prep_rem_neg;
                        hi_ge   <= prep_hi_ge;
                        state   <= mul_idle ? S_FIX : S_ITER;
                    end
                end
                S_ITER: begin
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1) || mul_idle)
                        state <= S_FIX;
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (is_div && div_ovf) begin
                        div_exc <= 1'b1;
                        cf_of   <= 1'b0;
                    end else begin
                        res_lo <= fix_lo;
                        res_hi <= fix_hi;
                        cf_of  <= fix_cf;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=16 with hand-computed results and latencies.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        byteop;
    logic [15:0] a_hi, a_lo, b;
    logic        busy, done, cf_of, div_exc;
    logic [15:0] res_lo, res_hi;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    int lat;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] IMUL = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] IDIV = 2'b11;

    muldiv_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .byteop    (byteop),
        .a_hi      (a_hi),
        .a_lo      (a_lo),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .cf_of     (cf_of),
        .div_exc   (div_exc),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present a request at a falling edge; returns after the sampling edge.
    task automatic launch(input logic [1:0] o, input logic bo,
                          input logic [15:0] h, input logic [15:0] l, input logic [15:0] bb);
        @(negedge clk);
        op = o; byteop = bo; a_hi = h; a_lo = l; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Same, but issued in the current (done) cycle without waiting.
    task automatic launch_now(input logic [1:0] o, input logic bo,
                              input logic [15:0] h, input logic [15:0] l, input logic [15:0] bb);
        op = o; byteop = bo; a_hi = h; a_lo = l; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges since the start edge until done; optionally pulses a stray start.
    task automatic wait_done(input int inj, output int l);
        l = 1;
        while (done !== 1'b1 && l < 64) begin
            if (l == inj) begin
                start = 1'b1; op = DIV; b = 16'h0000;
            end
            @(negedge clk);
            l++;
            start = 1'b0;
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; op = MUL; byteop = 1'b0;
        a_hi = '0; a_lo = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_lo",    res_lo,    16'h0000);
        chk("rst_hi",    res_hi,    16'h0000);
        chk("rst_cf",    cf_of,     1'b0);
        chk("rst_exc",   div_exc,   1'b0);
        chk("rst_state", dbg_state, 2'b00);
        rst = 1'b1;

        // MUL word 0x1234 * 0x0100 = 0x00123400
        launch(MUL, 1'b0, 16'h0, 16'h1234, 16'h0100);
        wait_done(0, lat);
        chk("mul_w_lat",  lat,     18);
        chk("mul_w_lo",   res_lo,  16'h3400);
        chk("mul_w_hi",   res_hi,  16'h0012);
        chk("mul_w_cf",   cf_of,   1'b1);
        chk("mul_w_exc",  div_exc, 1'b0);
        chk("mul_w_busy", busy,    1'b0);

        // DIV by zero: early done with exception, results kept
        launch(DIV, 1'b0, 16'h0000, 16'h0005, 16'h0000);
        wait_done(0, lat);
        chk("dz_lat", lat,     2);
        chk("dz_exc", div_exc, 1'b1);
        chk("dz_lo",  res_lo,  16'h3400);
        chk("dz_hi",  res_hi,  16'h0012);
        chk("dz_cf",  cf_of,   1'b0);
        @(negedge clk);
        chk("dz_done_pulse", done, 1'b0);

        // IMUL byte -2 * 3 = -6
        launch(IMUL, 1'b1, 16'h0, 16'h00FE, 16'h0003);
        wait_done(0, lat);
        chk("imul_b_lat", lat,    10);
        chk("imul_b_lo",  res_lo, 16'hFFFA);
        chk("imul_b_hi",  res_hi, 16'h0000);
        chk("imul_b_cf",  cf_of,  1'b0);

        // DIV word 0x00010000 / 0x10 = 0x1000 r 0
        launch(DIV, 1'b0, 16'h0001, 16'h0000, 16'h0010);
        wait_done(0, lat);
        chk("div_w_lat", lat,     18);
        chk("div_w_lo",  res_lo,  16'h1000);
        chk("div_w_hi",  res_hi,  16'h0000);
        chk("div_w_exc", div_exc, 1'b0);

        // IDIV byte -7 / 2 = -3 r -1
        launch(IDIV, 1'b1, 16'h0, 16'hFFF9, 16'h0002);
        wait_done(0, lat);
        chk("idiv_b_lat", lat,     10);
        chk("idiv_b_lo",  res_lo,  16'hFFFD);
        chk("idiv_b_hi",  res_hi,  16'h0000);
        chk("idiv_b_exc", div_exc, 1'b0);

        // Start in the done cycle is accepted: MUL 0xFFFF * 0xFFFF = 0xFFFE0001
        launch_now(MUL, 1'b0, 16'h0, 16'hFFFF, 16'hFFFF);
        wait_done(0, lat);
        chk("b2b_lat", lat,    18);
        chk("b2b_lo",  res_lo, 16'h0001);
        chk("b2b_hi",  res_hi, 16'hFFFE);
        chk("b2b_cf",  cf_of,  1'b1);

        // IMUL word -1 * -1 = 1
        launch(IMUL, 1'b0, 16'h0, 16'hFFFF, 16'hFFFF);
        wait_done(0, lat);
        chk("imul_w_lo", res_lo, 16'h0001);
        chk("imul_w_hi", res_hi, 16'h0000);
        chk("imul_w_cf", cf_of,  1'b0);

        // IDIV word -100 / 7 = -14 r -2
        launch(IDIV, 1'b0, 16'hFFFF, 16'hFF9C, 16'h0007);
        wait_done(0, lat);
        chk("idiv_w_lo",  res_lo,  16'hFFF2);
        chk("idiv_w_hi",  res_hi,  16'hFFFE);
        chk("idiv_w_exc", div_exc, 1'b0);

        // DIV word quotient overflow 0x00100000 / 1
        launch(DIV, 1'b0, 16'h0010, 16'h0000, 16'h0001);
        wait_done(0, lat);
        chk("dovf_lat", lat,     18);
        chk("dovf_exc", div_exc, 1'b1);
        chk("dovf_lo",  res_lo,  16'hFFF2);
        chk("dovf_hi",  res_hi,  16'hFFFE);

        // IDIV byte -128 / -1: quotient +128 out of signed range
        launch(IDIV, 1'b1, 16'h0, 16'hFF80, 16'h00FF);
        wait_done(0, lat);
        chk("iovf_lat", lat,     10);
        chk("iovf_exc", div_exc, 1'b1);
        chk("iovf_lo",  res_lo,  16'hFFF2);

        // Stray start while busy is ignored: 0x1234 * 0x5678 = 0x06260060
        launch(MUL, 1'b0, 16'h0, 16'h1234, 16'h5678);
        wait_done(5, lat);
        chk("ign_lat", lat,     18);
        chk("ign_lo",  res_lo,  16'h0060);
        chk("ign_hi",  res_hi,  16'h0626);
        chk("ign_exc", div_exc, 1'b0);
        @(negedge clk);
        chk("ign_busy_after", busy, 1'b0);

        // Asynchronous reset in the middle of iterating
        launch(MUL, 1'b0, 16'h0, 16'h1234, 16'h5678);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_done",  done,      1'b0);
        chk("mid_rst_lo",    res_lo,    16'h0000);
        chk("mid_rst_hi",    res_hi,    16'h0000);
        chk("mid_rst_state", dbg_state, 2'b00);
        repeat (3) @(negedge clk);
        chk("mid_rst_nodone", done, 1'b0);
        rst = 1'b1;

        // Normal operation after reset release
        launch(DIV, 1'b0, 16'h0001, 16'h0000, 16'h0010);
        wait_done(0, lat);
        chk("post_lat", lat,    18);
        chk("post_lo",  res_lo, 16'h1000);
        chk("post_hi",  res_hi, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
